// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle register-register execute controller: READ operands, EXEC via external ALU,
// WB result and latch flags into PSR. Optional retire counter enabled by `define RETIRE_CNT_EN.
module rtype_exec_ctrl #(
    parameter int WIDTH   = 16,
    parameter int NUMREGS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid,
    input  logic [15:0]                instr,
    output logic                       instr_ready,
    output logic [$clog2(NUMREGS)-1:0] rf_src_addr,
    output logic [$clog2(NUMREGS)-1:0] rf_dst_addr,
    input  logic [WIDTH-1:0]           rf_read_data1,
    input  logic [WIDTH-1:0]           rf_read_data2,
    output logic                       rf_write_en,
    output logic [WIDTH-1:0]           rf_write_data,
    output logic [7:0]                 alu_op,
    output logic [WIDTH-1:0]           alu_in1,
    output logic [WIDTH-1:0]           alu_in2,
    input  logic [WIDTH-1:0]           alu_out,
    input  logic [1:0]                 cond_group1,
    input  logic [2:0]                 cond_group2,
    output logic [4:0]                 psr,
    output logic                       busy,
    output logic                       done,
`ifdef RETIRE_CNT_EN
    output logic [15:0]                retire_cnt,
`endif
    output logic [1:0]                 dbg_state_o
);

    localparam int AW = $clog2(NUMREGS);
    localparam logic [7:0] OP_CMP = 8'b1011_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      instr_q;
    logic [7:0]       alu_op_q;
    logic [WIDTH-1:0] alu_in1_q, alu_in2_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       flags_q;
    logic [4:0]       psr_q;
    logic             accept;

    // Handshake: an instruction is taken on any edge where instr_valid && instr_ready;
    // instr_ready is high only in IDLE and WB, so requests in READ/EXEC are simply not taken.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = READ;
            end
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB: begin
                instr_ready = 1'b1;
                state_d     = instr_valid ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            alu_op_q  <= '0;
            alu_in1_q <= '0;
            alu_in2_q <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            psr_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) instr_q <= instr;
            // Port B reads Rdest (first ALU operand), port A reads Rsrc (second operand).
            if (state_q == READ) begin
                alu_in1_q <= rf_read_data2;
                alu_in2_q <= rf_read_data1;
                alu_op_q  <= {instr_q[15:12], instr_q[7:4]};
            end
            if (state_q == EXEC) begin
                result_q <= alu_out;
                flags_q  <= {cond_group2, cond_group1};
            end
            if (state_q == WB) psr_q <= flags_q;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [15:0] retire_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else if (state_q == WB) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

    // Write strobe is decoded from state so an asynchronous reset kills it immediately.
    assign rf_write_en   = (state_q == WB) && (alu_op_q != OP_CMP);
    assign rf_write_data = (state_q == WB) ? result_q : '0;
    assign rf_src_addr   = instr_q[AW-1:0];
    assign rf_dst_addr   = instr_q[8 +: AW];
    assign alu_op        = alu_op_q;
    assign alu_in1       = alu_in1_q;
    assign alu_in2       = alu_in2_q;
    assign psr           = psr_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == WB);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Bench for rtype_exec_ctrl: behavioural register file and ALU around the controller,
// scoreboard of expected write-backs checked on every done pulse.
module tb_rtype_exec_ctrl;

    localparam int W  = 16;
    localparam int EW = 26;  // {we, rd[3:0], data[15:0], psr[4:0]}

    localparam logic [15:0] I_ADD_R1_R2 = 16'h0152;
    localparam logic [15:0] I_SUB_R1_R1 = 16'h0191;
    localparam logic [15:0] I_SUB_R3_R4 = 16'h0394;
    localparam logic [15:0] I_CMP_R5_R6 = 16'hB506;
    localparam logic [15:0] I_AND_R9_RA = 16'h091A;
    localparam logic [15:0] I_XOR_R7_R8 = 16'h0738;
    localparam logic [15:0] I_ADD_RB_RC = 16'h0B5C;

    logic         clk = 1'b0;
    logic         reset;
    logic         instr_valid;
    logic [15:0]  instr;
    logic         instr_ready;
    logic [3:0]   rf_src_addr, rf_dst_addr;
    logic [W-1:0] rf_read_data1, rf_read_data2;
    logic         rf_write_en;
    logic [W-1:0] rf_write_data;
    logic [7:0]   alu_op;
    logic [W-1:0] alu_in1, alu_in2, alu_out;
    logic [1:0]   cond_group1;
    logic [2:0]   cond_group2;
    logic [4:0]   psr;
    logic         busy, done;
    logic [1:0]   dbg_state;
`ifdef RETIRE_CNT_EN
    logic [15:0]  retire_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int retired     = 0;
    int cyc         = 0;

    logic [W-1:0]  regs   [16];
    logic [W-1:0]  shadow [16];
    logic [EW-1:0] exp_q[$];

    logic         pl_en = 1'b0;
    logic [3:0]   pl_addr = '0;
    logic [W-1:0] pl_data = '0;

    rtype_exec_ctrl #(.WIDTH(16), .NUMREGS(16)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_src_addr(rf_src_addr), .rf_dst_addr(rf_dst_addr),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_write_en(rf_write_en), .rf_write_data(rf_write_data), .alu_op(alu_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .cond_group1(cond_group1), .cond_group2(cond_group2), .psr(psr),
        .busy(busy), .done(done),
`ifdef RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- register file and ALU stand-ins ----------------
    always @(posedge clk) begin
        if (pl_en) regs[pl_addr] <= pl_data;
        else if (rf_write_en) regs[rf_dst_addr] <= rf_write_data;
    end

    assign rf_read_data1 = regs[rf_src_addr];
    assign rf_read_data2 = regs[rf_dst_addr];

    // Stand-in ALU flags: ADD/SUB -> {C, V} low, Z high-middle; CMP -> signed-less low,
    // unsigned-less high-middle; logic ops -> Z only.
    function automatic logic [20:0] alu_f(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic [2:0]  g2;
        logic [1:0]  g1;
        s = '0; r = '0; g2 = '0; g1 = '0;
        case (op)
            8'h05: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[15:0];
                g1 = {s[16], (a[15] == b[15]) && (r[15] != a[15])};
                g2 = {1'b0, r == 16'h0, 1'b0};
            end
            8'h09: begin
                r  = a - b;
                g1 = {a < b, (a[15] != b[15]) && (r[15] != a[15])};
                g2 = {1'b0, r == 16'h0, 1'b0};
            end
            8'hB0: begin
                r  = a - b;
                g1 = {$signed(a) < $signed(b), 1'b0};
                g2 = {1'b0, a < b, 1'b0};
            end
            8'h01: begin r = a & b; g2 = {1'b0, r == 16'h0, 1'b0}; end
            8'h03: begin r = a ^ b; g2 = {1'b0, r == 16'h0, 1'b0}; end
            default: r = '0;
        endcase
        return {g2, g1, r};
    endfunction

    assign {cond_group2, cond_group1, alu_out} = alu_f(alu_op, alu_in1, alu_in2);

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [3:0] a, input logic [W-1:0] v);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        shadow[a] = v;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic push_expect(input logic [15:0] ins);
        logic [3:0]  rd, rs;
        logic [7:0]  op;
        logic [20:0] f;
        logic        we;
        rd = ins[11:8]; rs = ins[3:0]; op = {ins[15:12], ins[7:4]};
        f  = alu_f(op, shadow[rd], shadow[rs]);
        we = (op != 8'hB0);
        exp_q.push_back({we, rd, f[15:0], f[20:16]});
        if (we) shadow[rd] = f[15:0];
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic drive_instr(input logic [15:0] ins, output int acc_cyc);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr = ins;
        while (instr_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_timeout: instr_ready=%b required 1", instr_ready);
        end
        push_expect(ins);
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] sb_e;
    logic [4:0]    psr_exp;
    logic          psr_pend = 1'b0;

    task automatic scoreboard_loop();
        forever begin
            @(negedge clk);
            if (psr_pend) begin
                vectors++;
                if (psr !== psr_exp) begin
                    miscompares++;
                    $display("FAIL sb_psr: psr=%b required %b", psr, psr_exp);
                end
                psr_pend = 1'b0;
            end
            if (done === 1'b1) begin
                retired++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_retire: dst=%0d data=%h required no retire", rf_dst_addr, rf_write_data);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (rf_write_en !== sb_e[25] || rf_dst_addr !== sb_e[24:21] ||
                        (sb_e[25] && rf_write_data !== sb_e[20:5])) begin
                        miscompares++;
                        $display("FAIL sb_writeback: we=%b dst=%0d data=%h required we=%b dst=%0d data=%h",
                                 rf_write_en, rf_dst_addr, rf_write_data, sb_e[25], sb_e[24:21], sb_e[20:5]);
                    end
                    psr_exp  = sb_e[4:0];
                    psr_pend = 1'b1;
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rf_write_en !== 1'b0 ||
            psr !== 5'b0 || alu_op !== 8'h0 || alu_in1 !== '0 || alu_in2 !== '0 ||
            dbg_state !== 2'd0 || rf_src_addr !== 4'h0 || rf_dst_addr !== 4'h0 || rf_write_data !== '0) begin
            miscompares++;
            $display("FAIL reset_values: rdy=%b busy=%b done=%b we=%b psr=%b op=%h in1=%h in2=%h st=%0d required rdy=1, others 0",
                     instr_ready, busy, done, rf_write_en, psr, alu_op, alu_in1, alu_in2, dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (instr_ready !== 1'b1 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_release: rdy=%b st=%0d required rdy=1 st=0", instr_ready, dbg_state);
        end
    endtask

    task automatic test_add_dependent();
        preload(4'd1, 16'h0003);
        preload(4'd2, 16'h0003);
        instr_valid = 1'b1; instr = I_ADD_R1_R2; push_expect(I_ADD_R1_R2);
        @(negedge clk);  // READ
        instr_valid = 1'b0;
        vectors++;
        if (dbg_state !== 2'd1 || instr_ready !== 1'b0 || busy !== 1'b1 || rf_write_en !== 1'b0 ||
            rf_src_addr !== 4'd2 || rf_dst_addr !== 4'd1) begin
            miscompares++;
            $display("FAIL add_read: st=%0d rdy=%b busy=%b we=%b src=%0d dst=%0d required st=1 rdy=0 busy=1 we=0 src=2 dst=1",
                     dbg_state, instr_ready, busy, rf_write_en, rf_src_addr, rf_dst_addr);
        end
        @(negedge clk);  // EXEC
        vectors++;
        if (alu_op !== 8'h05 || alu_in1 !== 16'h0003 || alu_in2 !== 16'h0003 || rf_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL add_exec: op=%h in1=%h in2=%h we=%b required op=05 in1=0003 in2=0003 we=0",
                     alu_op, alu_in1, alu_in2, rf_write_en);
        end
        instr_valid = 1'b1; instr = I_SUB_R1_R1; push_expect(I_SUB_R1_R1);
        @(negedge clk);  // WB, third cycle after acceptance
        vectors++;
        if (rf_write_en !== 1'b1 || done !== 1'b1 || instr_ready !== 1'b1 || rf_write_data !== 16'h0006) begin
            miscompares++;
            $display("FAIL add_wb: we=%b done=%b rdy=%b data=%h required we=1 done=1 rdy=1 data=0006",
                     rf_write_en, done, instr_ready, rf_write_data);
        end
        @(negedge clk);  // READ of SUB
        instr_valid = 1'b0;
        vectors++;
        if (regs[1] !== 16'h0006 || psr !== 5'b00000 || dbg_state !== 2'd1) begin
            miscompares++;
            $display("FAIL add_result: R1=%h psr=%b st=%0d required R1=0006 psr=00000 st=1", regs[1], psr, dbg_state);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (regs[1] !== 16'h0000 || psr !== 5'b01000 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL sub_dependent: R1=%h psr=%b st=%0d required R1=0000 psr=01000 st=0", regs[1], psr, dbg_state);
        end
    endtask

    task automatic test_sub_underflow();
        int dcount;
        dcount = 0;
        preload(4'd3, 16'h0000);
        preload(4'd4, 16'h0001);
        instr_valid = 1'b1; instr = I_SUB_R3_R4; push_expect(I_SUB_R3_R4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) instr_valid = 1'b0;
            if (done === 1'b1) dcount++;
        end
        vectors++;
        if (regs[3] !== 16'hFFFF || psr !== 5'b00010 || dcount != 1) begin
            miscompares++;
            $display("FAIL sub_underflow: R3=%h psr=%b done_cycles=%0d required R3=ffff psr=00010 done_cycles=1",
                     regs[3], psr, dcount);
        end
    endtask

    task automatic test_cmp();
        logic we_seen;
        we_seen = 1'b0;
        preload(4'd5, 16'h0001);
        preload(4'd6, 16'h007F);
        instr_valid = 1'b1; instr = I_CMP_R5_R6; push_expect(I_CMP_R5_R6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) instr_valid = 1'b0;
            if (rf_write_en === 1'b1) we_seen = 1'b1;
        end
        vectors++;
        if (we_seen !== 1'b0 || regs[5] !== 16'h0001 || psr !== 5'b01010) begin
            miscompares++;
            $display("FAIL cmp: we_seen=%b R5=%h psr=%b required we_seen=0 R5=0001 psr=01010", we_seen, regs[5], psr);
        end
    endtask

    task automatic test_reset_midop();
        preload(4'd7, 16'h1234);
        preload(4'd8, 16'h00FF);
        instr_valid = 1'b1; instr = I_XOR_R7_R8;
        @(negedge clk);  // READ
        instr_valid = 1'b0;
        @(negedge clk);  // EXEC
        reset = 1'b1;
        #1;
        vectors++;
        if (rf_write_en !== 1'b0 || psr !== 5'b0 || dbg_state !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midop_async: we=%b psr=%b st=%0d busy=%b required we=0 psr=00000 st=0 busy=0",
                     rf_write_en, psr, dbg_state, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (regs[7] !== 16'h1234 || instr_ready !== 1'b1 || dbg_state !== 2'd0 || psr !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_midop_after: R7=%h rdy=%b st=%0d psr=%b required R7=1234 rdy=1 st=0 psr=00000",
                     regs[7], instr_ready, dbg_state, psr);
        end
    endtask

    task automatic test_busy_ignore();
        int r0;
        preload(4'd9,  16'h00F0);
        preload(4'd10, 16'h0F0F);
        preload(4'd11, 16'h0005);
        preload(4'd12, 16'h0009);
        r0 = retired;
        instr_valid = 1'b1; instr = I_ADD_RB_RC; push_expect(I_ADD_RB_RC);
        @(negedge clk);  // READ
        instr = I_AND_R9_RA;
        vectors++;
        if (instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ready_read: rdy=%b required 0", instr_ready);
        end
        @(negedge clk);  // EXEC
        vectors++;
        if (instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ready_exec: rdy=%b required 0", instr_ready);
        end
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (regs[11] !== 16'h000E || regs[9] !== 16'h00F0 || dbg_state !== 2'd0 || (retired - r0) != 1) begin
            miscompares++;
            $display("FAIL busy_ignore: R11=%h R9=%h st=%0d retired=%0d required R11=000e R9=00f0 st=0 retired=1",
                     regs[11], regs[9], dbg_state, retired - r0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [5];
        int prev_acc, acc;
        logic [15:0] ins;
        ops[0] = 8'h05; ops[1] = 8'h09; ops[2] = 8'hB0; ops[3] = 8'h01; ops[4] = 8'h03;
        for (int r = 0; r < 16; r++) preload(r[3:0], 16'($urandom_range(0, 16'hFFFF)));
        prev_acc = -100;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] op;
            op  = ops[$urandom_range(0, 4)];
            ins = {op[7:4], 4'($urandom_range(0, 15)), op[3:0], 4'($urandom_range(0, 15))};
            if (k >= 12 && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            drive_instr(ins, acc);
            if (k > 0 && k < 12) begin
                vectors++;
                if (acc - prev_acc != 3) begin
                    miscompares++;
                    $display("FAIL b2b_throughput: spacing=%0d cycles required 3", acc - prev_acc);
                end
            end
            prev_acc = acc;
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL b2b_drain: pending=%0d st=%0d required pending=0 st=0", exp_q.size(), dbg_state);
        end
        for (int r = 0; r < 16; r++) begin
            vectors++;
            if (regs[r] !== shadow[r]) begin
                miscompares++;
                $display("FAIL b2b_regfile: R%0d=%h required %h", r, regs[r], shadow[r]);
            end
        end
    endtask

`ifdef RETIRE_CNT_EN
    task automatic test_retire_wrap();
        int acc;
        force dut.retire_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.retire_cnt_q;
        drive_instr(I_CMP_R5_R6, acc);
        repeat (4) @(negedge clk);
        vectors++;
        if (retire_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL retire_wrap: retire_cnt=%h required 0000", retire_cnt);
        end
    endtask
`endif

    initial begin
        for (int r = 0; r < 16; r++) begin
            regs[r]   = '0;
            shadow[r] = '0;
        end
        fork
            scoreboard_loop();
        join_none
        test_reset();
        test_add_dependent();
        test_sub_underflow();
        test_cmp();
        test_reset_midop();
        test_busy_ignore();
        test_back_to_back();
`ifdef RETIRE_CNT_EN
        test_retire_wrap();
`endif
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
